// File: rtl/axi_write_master.sv
// AXI3-style single-outstanding write master: sequences one AW handshake, len+1 W beats and
// the B response, then reports completion as a one-cycle resp_valid pulse (2'b11 on timeout).
module axi_write_master #(
  parameter int unsigned buswidth = 32,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic [3:0]          req_len,
  input  logic [2:0]          req_size,
  input  logic [1:0]          req_burst,
  input  logic [3:0]          req_id,
  input  logic [buswidth-1:0] wdata_in,
  input  logic [3:0]          wstrb_in,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  output logic                resp_valid,
  output logic [1:0]          resp_code,
  output logic [3:0]          resp_id,
  output logic                busy,
  output logic [3:0]          AWID,
  output logic [31:0]         AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic [1:0]          AWLOCK,
  output logic [3:0]          AWCACHE,
  output logic [2:0]          AWPROT,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [3:0]          WID,
  output logic [buswidth-1:0] WDATA,
  output logic [3:0]          WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [3:0]          BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

  localparam int unsigned      TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0]    TO_LAST = TW'(TIMEOUT - 1);
  localparam bit               TO_EN   = (TIMEOUT != 0);

  state_e              state_q, state_d;
  logic [3:0]          awid_q, awid_d;
  logic [31:0]         awaddr_q, awaddr_d;
  logic [3:0]          awlen_q, awlen_d;
  logic [2:0]          awsize_q, awsize_d;
  logic [1:0]          awburst_q, awburst_d;
  logic                awvalid_q, awvalid_d;
  logic [3:0]          wid_q, wid_d;
  logic [buswidth-1:0] wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                wlast_q, wlast_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          rcode_q, rcode_d;
  logic [3:0]          rid_q, rid_d;
  logic [4:0]          beat_q, beat_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                beat_fire;

  // Holding req_ready low during the completion pulse keeps the next accept at least one cycle later.
  assign req_ready   = (state_q == S_IDLE) & ~rvalid_q;
  assign busy        = (state_q != S_IDLE);
  assign wdata_ready = (state_q == S_DATA) & (~wvalid_q | WREADY) & (beat_q <= {1'b0, awlen_q});
  assign beat_fire   = wdata_valid & wdata_ready;

  always_comb begin
    state_d   = state_q;
    awid_d    = awid_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    awvalid_d = awvalid_q;
    wid_d     = wid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wlast_d   = wlast_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    rvalid_d  = 1'b0;
    rcode_d   = rcode_q;
    rid_d     = rid_q;
    beat_d    = beat_q;
    tmo_d     = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          awid_d    = req_id;
          awaddr_d  = req_addr;
          awlen_d   = req_len;
          awsize_d  = req_size;
          awburst_d = req_burst;
          awvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (AWREADY) begin
          awvalid_d = 1'b0;
          beat_d    = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (beat_fire) begin
          wdata_d  = wdata_in;
          wstrb_d  = wstrb_in;
          wid_d    = awid_q;
          wvalid_d = 1'b1;
          wlast_d  = (beat_q == {1'b0, awlen_q});
          beat_d   = beat_q + 5'd1;
        end else if (wvalid_q && WREADY) begin
          wvalid_d = 1'b0;
          if (wlast_q) begin
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            tmo_d    = '0;
            state_d  = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (BVALID) begin
          rvalid_d = 1'b1;
          rcode_d  = BRESP;
          rid_d    = BID;
          bready_d = 1'b0;
          state_d  = S_IDLE;
        end else if (TO_EN && (tmo_q == TO_LAST)) begin
          rvalid_d = 1'b1;
          rcode_d  = 2'b11;
          rid_d    = awid_q;
          bready_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= S_IDLE;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      awvalid_q <= 1'b0;
      wid_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wlast_q   <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rcode_q   <= '0;
      rid_q     <= '0;
      beat_q    <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      awid_q    <= awid_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      awburst_q <= awburst_d;
      awvalid_q <= awvalid_d;
      wid_q     <= wid_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wlast_q   <= wlast_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      rvalid_q  <= rvalid_d;
      rcode_q   <= rcode_d;
      rid_q     <= rid_d;
      beat_q    <= beat_d;
      tmo_q     <= tmo_d;
    end
  end

  assign AWID       = awid_q;
  assign AWADDR     = awaddr_q;
  assign AWLEN      = awlen_q;
  assign AWSIZE     = awsize_q;
  assign AWBURST    = awburst_q;
  assign AWLOCK     = 2'b00;
  assign AWCACHE    = 4'b0000;
  assign AWPROT     = 3'b000;
  assign AWVALID    = awvalid_q;
  assign WID        = wid_q;
  assign WDATA      = wdata_q;
  assign WSTRB      = wstrb_q;
  assign WLAST      = wlast_q;
  assign WVALID     = wvalid_q;
  assign BREADY     = bready_q;
  assign resp_valid = rvalid_q;
  assign resp_code  = rcode_q;
  assign resp_id    = rid_q;

endmodule

// File: tb/tb_axi_write_master.sv
// Bench for axi_write_master: device-side driver, AXI slave model and a queue-based scoreboard.
module tb_axi_write_master;
  localparam int BW  = 32;
  localparam int TMO = 16;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          req_valid, req_ready;
  logic [31:0]   req_addr;
  logic [3:0]    req_len;
  logic [2:0]    req_size;
  logic [1:0]    req_burst;
  logic [3:0]    req_id;
  logic [BW-1:0] wdata_in;
  logic [3:0]    wstrb_in;
  logic          wdata_valid, wdata_ready;
  logic          resp_valid;
  logic [1:0]    resp_code;
  logic [3:0]    resp_id;
  logic          busy;
  logic [3:0]    AWID;
  logic [31:0]   AWADDR;
  logic [3:0]    AWLEN;
  logic [2:0]    AWSIZE;
  logic [1:0]    AWBURST, AWLOCK;
  logic [3:0]    AWCACHE;
  logic [2:0]    AWPROT;
  logic          AWVALID, AWREADY;
  logic [3:0]    WID;
  logic [BW-1:0] WDATA;
  logic [3:0]    WSTRB;
  logic          WLAST, WVALID, WREADY;
  logic [3:0]    BID;
  logic [1:0]    BRESP;
  logic          BVALID, BREADY;

  axi_write_master #(.buswidth(BW), .TIMEOUT(TMO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .req_size(req_size), .req_burst(req_burst), .req_id(req_id),
    .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .resp_valid(resp_valid), .resp_code(resp_code), .resp_id(resp_id), .busy(busy),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct { logic [31:0] addr; logic [3:0] len; logic [2:0] size; logic [1:0] burst; logic [3:0] id; } aw_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; logic [3:0] id; } w_t;
  typedef struct { logic [1:0] code; logic [3:0] id; } r_t;

  aw_t aw_q[$];
  w_t  w_q[$];
  r_t  r_q[$];
  aw_t ea;
  w_t  ew;
  r_t  er, rb;

  int vectors = 0;
  int errors  = 0;

  // slave-model knobs and monitor statistics
  int   aw_delay = 0, b_delay = 0, stall_beat = -1;
  bit   w_rand = 1'b0, b_never = 1'b0, b_fix = 1'b0;
  logic [3:0] b_fix_id = 4'd0;
  int   aw_wait, b_wait, stall_cnt = 0;
  int   w_rcvd = 0, w_idle = 0, w_stall_cyc = 0, resp_cnt = 0, aw_cyc = 0, last_aw_cyc = 0;
  bit   prev_aw_stall = 1'b0, prev_w_stall = 1'b0, prev_resp = 1'b0;
  logic [31:0]   prev_awaddr;
  logic [BW-1:0] prev_wdata;
  logic          prev_wlast;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // AXI slave: AW ready after aw_delay cycles
  initial begin
    AWREADY = 1'b0; aw_wait = 0;
    forever begin
      @(posedge ACLK); #1;
      if (!AWVALID) begin AWREADY = 1'b0; aw_wait = 0; end
      else if (aw_wait >= aw_delay) AWREADY = 1'b1;
      else begin AWREADY = 1'b0; aw_wait++; end
    end
  end

  // AXI slave: W ready, random or with a 2-cycle stall on a chosen beat
  initial begin
    WREADY = 1'b0;
    forever begin
      @(posedge ACLK); #1;
      if (WVALID && w_rcvd == stall_beat && stall_cnt < 2) begin WREADY = 1'b0; stall_cnt++; end
      else WREADY = w_rand ? ($urandom_range(3, 0) != 0) : 1'b1;
    end
  end

  // AXI slave: B response after b_delay cycles of BREADY; the expected completion is queued here
  initial begin
    BVALID = 1'b0; BRESP = 2'b00; BID = 4'd0; b_wait = 0;
    forever begin
      @(posedge ACLK); #1;
      if (BVALID) BVALID = 1'b0;
      else if (BREADY && !b_never) begin
        if (b_wait >= b_delay) begin
          BRESP = b_fix ? 2'b00 : 2'($urandom);
          BID   = b_fix ? b_fix_id : 4'($urandom);
          BVALID = 1'b1;
          rb.code = BRESP; rb.id = BID;
          r_q.push_back(rb);
          b_wait = 0;
        end else b_wait++;
      end else b_wait = 0;
    end
  end

  // monitor / scoreboard
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      prev_aw_stall = 1'b0; prev_w_stall = 1'b0; prev_resp = 1'b0; aw_cyc = 0;
    end else begin
      if (prev_aw_stall) begin
        check("aw_hold_valid", AWVALID, 1);
        check("aw_hold_addr", AWADDR, prev_awaddr);
      end
      if (prev_w_stall) begin
        check("w_hold_valid", WVALID, 1);
        check("w_hold_data", WDATA, prev_wdata);
        check("w_hold_last", WLAST, prev_wlast);
      end
      if (aw_q.size() > 0) check("w_before_aw", WVALID, 0);
      if (prev_resp) check("ready_after_resp", req_ready, 1);
      if (AWVALID) aw_cyc++;
      if (AWVALID && AWREADY) begin
        if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          ea = aw_q.pop_front();
          check("awaddr", AWADDR, ea.addr);
          check("awlen", AWLEN, ea.len);
          check("awsize", AWSIZE, ea.size);
          check("awburst", AWBURST, ea.burst);
          check("awid", AWID, ea.id);
          check("aw_fixed", {AWLOCK, AWCACHE, AWPROT}, 9'd0);
        end
        last_aw_cyc = aw_cyc; aw_cyc = 0;
      end
      if (WVALID && WREADY) begin
        if (w_q.size() == 0) check("w_unexpected", 1, 0);
        else begin
          ew = w_q.pop_front();
          check("wdata", WDATA, ew.data);
          check("wstrb", WSTRB, ew.strb);
          check("wlast", WLAST, ew.last);
          check("wid", WID, ew.id);
        end
        w_rcvd++;
      end
      if (WVALID && !WREADY) w_stall_cyc++;
      if (busy && !AWVALID && aw_q.size() == 0 && !WVALID && !BREADY) w_idle++;
      if (resp_valid) begin
        check("no_accept_in_resp", req_ready, 0);
        if (r_q.size() == 0) check("resp_unexpected", 1, 0);
        else begin
          er = r_q.pop_front();
          check("resp_code", resp_code, er.code);
          check("resp_id", resp_id, er.id);
        end
        resp_cnt++;
      end
      prev_aw_stall = AWVALID && !AWREADY;
      prev_w_stall  = WVALID && !WREADY;
      prev_resp     = resp_valid;
      prev_awaddr   = AWADDR;
      prev_wdata    = WDATA;
      prev_wlast    = WLAST;
    end
  end

  task automatic issue_req(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [3:0] id);
    aw_t e;
    int n;
    w_rcvd = 0; stall_cnt = 0; w_idle = 0; w_stall_cyc = 0;
    req_addr = a; req_len = l; req_size = s; req_burst = b; req_id = id; req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge ACLK);
      if (req_ready) break;
      n++;
      if (n > 100) begin check("req_accept_bound", 0, 1); break; end
    end
    e.addr = a; e.len = l; e.size = s; e.burst = b; e.id = id;
    aw_q.push_back(e);
    @(posedge ACLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic last,
                           input logic [3:0] id, input int gap);
    w_t e;
    int n;
    wdata_in = d; wstrb_in = s; wdata_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge ACLK);
      if (wdata_ready) break;
      n++;
      if (n > 200) begin check("wdata_ready_bound", 0, 1); break; end
    end
    e.data = d; e.strb = s; e.last = last; e.id = id;
    w_q.push_back(e);
    @(posedge ACLK); #1;
    wdata_valid = 1'b0;
    repeat (gap) begin @(posedge ACLK); #1; end
  endtask

  task automatic wait_resp(input int n0);
    int n;
    n = 0;
    while (resp_cnt == n0 && n < 300) begin @(negedge ACLK); n++; end
    check("resp_count", resp_cnt - n0, 1);
    @(posedge ACLK); #1;
  endtask

  task automatic run_burst(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [3:0] id, input logic [31:0] base,
                           input bit rnd, input int gmin, input int gmax);
    int n0;
    logic [31:0] d;
    n0 = resp_cnt;
    issue_req(a, l, s, b, id);
    for (int i = 0; i <= int'(l); i++) begin
      d = rnd ? $urandom : base + 32'(i);
      send_beat(d, rnd ? 4'($urandom) : 4'hF, i == int'(l), id, $urandom_range(gmax, gmin));
    end
    wait_resp(n0);
    check("w_beats", w_rcvd, int'(l) + 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, rc, n;
    ARESETn = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; req_size = '0; req_burst = '0;
    req_id = '0; wdata_in = '0; wstrb_in = '0; wdata_valid = 1'b0;
    #12;
    check("rst_valids", {AWVALID, WVALID, WLAST, BREADY, resp_valid}, 5'b0);
    check("rst_aw", {AWID, AWADDR, AWLEN, AWSIZE, AWBURST}, 45'd0);
    check("rst_w", {WID, WDATA, WSTRB}, 40'd0);
    check("rst_ready_busy", {req_ready, busy, wdata_ready}, 3'b100);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    repeat (2) begin @(posedge ACLK); #1; end

    // single beat, AWREADY/WREADY immediate, BRESP=00 BID=3
    aw_delay = 0; w_rand = 0; b_delay = 0; b_fix = 1; b_fix_id = 4'd3;
    run_burst(32'h100, 4'd0, 3'd2, 2'b01, 4'd3, 32'h55, 0, 0, 0);
    check("t1_aw_cycles", last_aw_cyc, 1);
    b_fix = 0;

    // INCR len=3, 2-cycle WREADY stall on the second beat
    stall_beat = 1;
    run_burst(32'h2000, 4'd3, 3'd2, 2'b01, 4'd7, 32'hA0, 0, 0, 0);
    check("t2_stall_cycles", w_stall_cyc, 2);
    stall_beat = -1;

    // AWREADY delayed 5 cycles
    aw_delay = 5;
    run_burst(32'h3004, 4'd1, 3'd2, 2'b10, 4'd9, 32'h10, 0, 0, 0);
    check("t3_aw_cycles", last_aw_cyc, 6);
    aw_delay = 0;

    // BVALID withheld: forced completion after TMO cycles in RESP
    b_never = 1;
    n0 = resp_cnt;
    issue_req(32'h400, 4'd1, 3'd2, 2'b01, 4'd12);
    send_beat(32'h1, 4'hF, 1'b0, 4'd12, 0);
    send_beat(32'h2, 4'hF, 1'b1, 4'd12, 0);
    er.code = 2'b11; er.id = 4'd12;
    r_q.push_back(er);
    rc = 0; n = 0;
    forever begin
      @(negedge ACLK);
      if (resp_valid || n > 200) break;
      if (BREADY) rc++;
      n++;
    end
    check("t4_resp_cycles", rc, TMO);
    @(negedge ACLK);
    check("t4_idle_after", {req_ready, busy}, 2'b10);
    check("t4_resp_count", resp_cnt - n0, 1);
    b_never = 0;
    @(posedge ACLK); #1;

    // reset during the third data beat
    n0 = resp_cnt;
    issue_req(32'h500, 4'd3, 3'd2, 2'b01, 4'd5);
    send_beat(32'hB0, 4'hF, 1'b0, 4'd5, 0);
    send_beat(32'hB1, 4'hF, 1'b0, 4'd5, 0);
    wdata_in = 32'hB2; wdata_valid = 1'b1;
    #2 ARESETn = 1'b0;
    #1;
    check("t5_async_valids", {AWVALID, WVALID, WLAST, BREADY, resp_valid, busy}, 6'b0);
    wdata_valid = 1'b0;
    aw_q.delete(); w_q.delete(); r_q.delete();
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    repeat (4) begin @(posedge ACLK); #1; end
    check("t5_no_resp", resp_cnt - n0, 0);
    run_burst(32'h600, 4'd2, 3'd2, 2'b01, 4'd6, 32'hC0, 0, 0, 0);

    // device starves data; illegal burst code passes through
    run_burst(32'h700, 4'd2, 3'd1, 2'b11, 4'd1, 32'hD0, 0, 3, 3);
    check("t6_wvalid_gaps", w_idle >= 4, 1);

    // randomized bursts
    w_rand = 1;
    for (int k = 0; k < 30; k++) begin
      aw_delay = $urandom_range(3, 0);
      b_delay  = $urandom_range(3, 0);
      run_burst($urandom, 4'($urandom), 3'($urandom_range(2, 0)), 2'($urandom), 4'($urandom),
                32'd0, 1, 0, $urandom_range(2, 0));
    end

    check("end_aw_q", aw_q.size(), 0);
    check("end_w_q", w_q.size(), 0);
    check("end_r_q", r_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/axi_write_master.md
Name: axi_write_master

Overview:
- AXI3-style write master that drives the AW and W channels and consumes the B channel.
- Sits directly upstream of the bus write slave: a local device posts one burst request plus per-beat data, and this block sequences address, data beats and response.
- It returns a one-cycle completion pulse carrying the response code.
- It is a single-outstanding-transaction engine: no overlapping bursts.

Parameters:
- buswidth, 32, data bus width in bits (WDATA / wdata_in).
- TIMEOUT, 256, max cycles in RESP waiting for BVALID before forced completion; 0 disables the timeout.

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- req_valid  in  1  device burst request
- req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready
- req_addr  in  32  start address
- req_len  in  4  beats minus 1
- req_size  in  3  bytes per beat = 2**req_size
- req_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
- req_id  in  4  transaction ID
- wdata_in  in  buswidth  beat data
- wstrb_in  in  4  beat byte strobes
- wdata_valid  in  1  device beat available
- wdata_ready  out  1  beat consumed on wdata_valid & wdata_ready
- resp_valid  out  1  one-cycle completion pulse
- resp_code  out  2  BRESP, or 2'b11 on timeout
- resp_id  out  4  BID received, or latched ID on timeout
- busy  out  1  high whenever state != IDLE
- AWID  out  4
- AWADDR  out  32
- AWLEN  out  4
- AWSIZE  out  3
- AWBURST  out  2
- AWLOCK  out  2
- AWCACHE  out  4
- AWPROT  out  3
- AWVALID  out  1
- AWREADY  in  1
- WID  out  4
- WDATA  out  buswidth
- WSTRB  out  4
- WLAST  out  1
- WVALID  out  1
- WREADY  in  1
- BID  in  4
- BRESP  in  2
- BVALID  in  1
- BREADY  out  1

Behaviour:
- All outputs are registered except req_ready, wdata_ready and busy, which are decoded from state and registers.
- Reset (async, ARESETn=0):
  - state=IDLE.
  - AWVALID, WVALID, WLAST, BREADY and resp_valid = 0.
  - All address/data/ID/control outputs = 0.
  - beat counter = 0; timeout counter = 0.
  - Reset mid-burst abandons the transaction with no completion pulse.
- Fixed fields: AWLOCK=2'b00, AWCACHE=4'b0000, AWPROT=3'b000.
- IDLE:
  - req_ready=1.
  - On accept, latch id/addr/len/size/burst, drive AW* from them, set AWVALID=1 at the next edge, go to ADDR.
  - The accept cycle itself drives nothing onto the bus.
- ADDR:
  - Hold AWVALID and all AW* stable until AWREADY.
  - On AWVALID & AWREADY: clear AWVALID, go to DATA.
  - W beats are not issued before the AW handshake completes.
- DATA:
  - wdata_ready = (!WVALID | WREADY) & (beats issued <= len).
  - On a device beat: load WDATA/WSTRB, set WID=latched id, WVALID=1, WLAST=(beat index == len).
  - Beat index increments per device beat.
  - WVALID/WDATA/WSTRB/WLAST hold stable until WREADY.
  - On WREADY with no new beat loaded: WVALID=0.
  - Back-to-back beats sustain one beat per cycle when wdata_valid and WREADY are both held high.
  - On the WLAST handshake: WVALID=0, WLAST=0, BREADY=1, clear timeout counter, go to RESP.
  - The AWBURST value does not change W-side behaviour; the slave computes addresses.
- RESP:
  - BREADY=1.
  - On BVALID: resp_valid=1 for exactly one cycle, resp_code=BRESP, resp_id=BID, BREADY=0, go to IDLE.
  - Otherwise increment the timeout counter.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no BVALID: resp_valid pulse, resp_code=2'b11, resp_id=latched id, go to IDLE.
- A new request can be accepted no earlier than the cycle after resp_valid.
- req_len=0 gives a single beat with WLAST=1 on the first beat.
- Illegal req_burst=2'b11 is passed through unchanged; this block does not check it.

Test Plan:
- Single beat: req addr=0x100, len=0, size=2, id=3; AWREADY and WREADY tied high; BRESP=00 BID=3 one cycle after WLAST -> AWVALID for 1 cycle with AWADDR=0x100 AWLEN=0; one W beat with WLAST=1 WID=3; resp_valid pulse with resp_code=00 resp_id=3.
- INCR burst len=3 with data 0xA0..0xA3, WREADY low on the 2nd beat for 2 cycles -> WDATA=0xA1 held stable while stalled; WLAST only with 0xA3; exactly 4 W handshakes.
- AWREADY delayed 5 cycles -> AWVALID and AWADDR held constant; no WVALID before the AW handshake.
- BVALID never asserted, TIMEOUT=16 -> resp_valid with resp_code=11 after 16 RESP cycles; state IDLE and req_ready=1 on the next cycle.
- ARESETn pulsed low during DATA beat 2 -> all VALIDs 0 immediately (async); no resp_valid; a fresh request completes normally afterwards.
- Device starves data (wdata_valid gaps of 3 cycles, len=2) -> WVALID drops between beats; 3 beats total with correct WLAST.
